con_sym_gen_mc: RTL and testbench



---
 rtl/con_sym_gen_mc.sv | 184 ++++++++++++++++++
 tb/tb_con_sym_gen_mc.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/con_sym_gen_mc.sv
// Purpose : multi-channel 100BASE-T1 style side-stream scrambler, 3B2T ternary mapper,
//           tx_enable generator and receiver-lock hysteresis FSM (channels fully independent).
// Latency : TAn/TBn/tx_enable/loc_rcvr_status are registered, 1 clk_33m cycle after their inputs.
// Backpressure: none; every channel consumes its inputs every cycle.
// Ports   : clk_33m/rstn (sync, active-low); per channel ch, slice [ch*W +: W] of
//           seed/seed_load/tx_mode/master_slave/tx_data/rcv_vld in, tx_enable/TAn/TBn/loc_rcvr_status out.
// Option  : CON_LOCK_LOSS_CNT_EN adds lock_loss_cnt (8 bits/channel, saturating lock-loss count).
module con_sym_gen_mc #(
   parameter int NUM_CH     = 1,
   parameter int SEED_W     = 33,
   parameter int TAP_M      = 13,
   parameter int TAP_S      = 20,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input  logic                     clk_33m,
   input  logic                     rstn,
   input  logic [NUM_CH*SEED_W-1:0] seed,
   input  logic [NUM_CH-1:0]        seed_load,
   input  logic [NUM_CH*2-1:0]      tx_mode,
   input  logic [NUM_CH-1:0]        master_slave,
   input  logic [NUM_CH*3-1:0]      tx_data,
   input  logic [NUM_CH-1:0]        rcv_vld,
   output logic [NUM_CH-1:0]        tx_enable,
   output logic [NUM_CH*2-1:0]      TAn,
   output logic [NUM_CH*2-1:0]      TBn,
   output logic [NUM_CH-1:0]        loc_rcvr_status
`ifdef CON_LOCK_LOSS_CNT_EN
   ,
   output logic [NUM_CH*8-1:0]      lock_loss_cnt
`endif
);

   typedef enum logic {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_t;

   localparam logic [1:0] MODE_SEND_I = 2'd1;
   localparam logic [1:0] MODE_SEND_N = 2'd2;

   // 3B2T lookup, returns {TA, TB}. Value v maps to i = v (v<4) or v+1, TA = i/3-1, TB = i%3-1,
   // so i = 4 (the (0,0) pair) is skipped. Ternary code: 00 = 0, 01 = +1, 11 = -1.
   function automatic logic [3:0] map_3b2t(input logic [2:0] v);
      logic [3:0] r;
      case (v)
         3'd0:    r = {2'b11, 2'b11};
         3'd1:    r = {2'b11, 2'b00};
         3'd2:    r = {2'b11, 2'b01};
         3'd3:    r = {2'b00, 2'b11};
         3'd4:    r = {2'b00, 2'b01};
         3'd5:    r = {2'b01, 2'b11};
         3'd6:    r = {2'b01, 2'b00};
         default: r = {2'b01, 2'b01};
      endcase
      return r;
   endfunction

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      logic [SEED_W-1:0] seed_ch;
      logic [1:0]        mode_ch;
      logic [2:0]        data_ch;

      logic [SEED_W-1:0] lfsr, lfsr_nxt, lfsr_step;
      logic              fb_tap;
      logic [1:0]        ta_q, tb_q, ta_d, tb_d;
      logic              en_q, en_d;
      logic [3:0]        sym;

      lock_state_t       state, state_nxt;
      logic [7:0]        cnt, cnt_nxt, cnt_inc;

      assign seed_ch = seed[ch*SEED_W +: SEED_W];
      assign mode_ch = tx_mode[ch*2 +: 2];
      assign data_ch = tx_data[ch*3 +: 3];

      // ---------------- scrambler + symbol mapper ----------------
      assign fb_tap    = master_slave[ch] ? lfsr[TAP_M-1] : lfsr[TAP_S-1];
      assign lfsr_step = {lfsr[SEED_W-2:0], lfsr[SEED_W-1] ^ fb_tap};

      // The symbol is taken from the pre-step state; payload is whitened by the low 3 LFSR bits.
      always_comb begin
         lfsr_nxt = lfsr;
         ta_d     = 2'b00;
         tb_d     = 2'b00;
         en_d     = 1'b0;
         sym      = 4'b0000;
         if (seed_load[ch]) begin
            // An all-zero seed would lock the LFSR at zero forever.
            lfsr_nxt = (seed_ch == '0) ? SEED_W'(1) : seed_ch;
         end else if (mode_ch == MODE_SEND_I) begin
            sym          = map_3b2t(lfsr[2:0]);
            {ta_d, tb_d} = sym;
            en_d         = 1'b1;
            lfsr_nxt     = lfsr_step;
         end else if (mode_ch == MODE_SEND_N) begin
            sym          = map_3b2t(data_ch ^ lfsr[2:0]);
            {ta_d, tb_d} = sym;
            en_d         = 1'b1;
            lfsr_nxt     = lfsr_step;
         end
         // SEND_Z and the reserved code: LFSR holds, symbols (0,0), transmitter off.
      end

      always_ff @(posedge clk_33m) begin
         if (!rstn) begin
            lfsr <= SEED_W'(1);
            ta_q <= 2'b00;
            tb_q <= 2'b00;
            en_q <= 1'b0;
         end else begin
            lfsr <= lfsr_nxt;
            ta_q <= ta_d;
            tb_q <= tb_d;
            en_q <= en_d;
         end
      end

      // ---------------- receiver-lock hysteresis ----------------
      // cnt counts consecutive cycles of the condition that would change state
      // (valid while unlocked, invalid while locked); any opposite sample restarts it.
      assign cnt_inc = cnt + 8'd1;

      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         if (state == UNLOCKED) begin
            if (!rcv_vld[ch]) begin
               cnt_nxt = 8'd0;
            end else if (cnt_inc == 8'(LOCK_CNT)) begin
               state_nxt = LOCKED;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end else begin
            if (rcv_vld[ch]) begin
               cnt_nxt = 8'd0;
            end else if (cnt_inc == 8'(UNLOCK_CNT)) begin
               state_nxt = UNLOCKED;
               cnt_nxt   = 8'd0;
            end else begin
               cnt_nxt = cnt_inc;
            end
         end
      end

      always_ff @(posedge clk_33m) begin
         if (!rstn) begin
            state <= UNLOCKED;
            cnt   <= 8'd0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
         end
      end

      assign TAn[ch*2 +: 2]      = ta_q;
      assign TBn[ch*2 +: 2]      = tb_q;
      assign tx_enable[ch]       = en_q;
      assign loc_rcvr_status[ch] = (state == LOCKED);

`ifdef CON_LOCK_LOSS_CNT_EN
      logic       lock_lost;
      logic [7:0] loss_q;

      assign lock_lost = (state == LOCKED) && (state_nxt == UNLOCKED);

      // seed_load clears the counter even when a loss happens in the same cycle.
      always_ff @(posedge clk_33m) begin
         if (!rstn) begin
            loss_q <= 8'd0;
         end else if (seed_load[ch]) begin
            loss_q <= 8'd0;
         end else if (lock_lost && (loss_q != 8'hFF)) begin
            loss_q <= loss_q + 8'd1;
         end
      end

      assign lock_loss_cnt[ch*8 +: 8] = loss_q;
`endif
   end

endmodule

// File: tb/tb_con_sym_gen_mc.sv
// Self-checking bench for con_sym_gen_mc (NUM_CH = 4) against a behavioural reference model.
module tb_con_sym_gen_mc;

   localparam int NCH = 4;
   localparam int SW  = 33;

   logic              clk_33m;
   logic              rstn;
   logic [NCH*SW-1:0] seed;
   logic [NCH-1:0]    seed_load;
   logic [NCH*2-1:0]  tx_mode;
   logic [NCH-1:0]    master_slave;
   logic [NCH*3-1:0]  tx_data;
   logic [NCH-1:0]    rcv_vld;
   logic [NCH-1:0]    tx_enable;
   logic [NCH*2-1:0]  TAn;
   logic [NCH*2-1:0]  TBn;
   logic [NCH-1:0]    loc_rcvr_status;
`ifdef CON_LOCK_LOSS_CNT_EN
   logic [NCH*8-1:0]  lock_loss_cnt;
`endif

   int errors = 0;
   int checks = 0;

   con_sym_gen_mc #(
      .NUM_CH(NCH), .SEED_W(SW), .TAP_M(13), .TAP_S(20), .LOCK_CNT(16), .UNLOCK_CNT(4)
   ) dut (
      .clk_33m         (clk_33m),
      .rstn            (rstn),
      .seed            (seed),
      .seed_load       (seed_load),
      .tx_mode         (tx_mode),
      .master_slave    (master_slave),
      .tx_data         (tx_data),
      .rcv_vld         (rcv_vld),
      .tx_enable       (tx_enable),
      .TAn             (TAn),
      .TBn             (TBn),
      .loc_rcvr_status (loc_rcvr_status)
`ifdef CON_LOCK_LOSS_CNT_EN
      ,
      .lock_loss_cnt   (lock_loss_cnt)
`endif
   );

   initial clk_33m = 1'b0;
   always #5 clk_33m = ~clk_33m;

   // ---------------- reference model ----------------
   logic [SW-1:0] m_s   [NCH];
   logic [1:0]    m_ta  [NCH];
   logic [1:0]    m_tb  [NCH];
   logic          m_en  [NCH];
   logic          m_lk  [NCH];
   int            m_run [NCH];
   int            m_llc [NCH];

   function automatic logic [1:0] tern(input int t);
      if (t == 0) return 2'b00;
      else if (t > 0) return 2'b01;
      else return 2'b11;
   endfunction

   function automatic logic [SW-1:0] lfsr_adv(input logic [SW-1:0] s, input logic m);
      int tap;
      tap = m ? 13 : 20;
      return {s[SW-2:0], s[SW-1] ^ s[tap-1]};
   endfunction

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_edge();
      for (int ch = 0; ch < NCH; ch++) begin
         logic [SW-1:0] sd;
         logic [1:0]    md;
         int            v, i;
         sd = seed[ch*SW +: SW];
         md = tx_mode[ch*2 +: 2];
         if (!rstn) begin
            m_s[ch] = 1; m_ta[ch] = 0; m_tb[ch] = 0; m_en[ch] = 0;
            m_lk[ch] = 0; m_run[ch] = 0; m_llc[ch] = 0;
         end else begin
            if (seed_load[ch]) begin
               m_s[ch] = (sd == 0) ? 1 : sd;
               m_ta[ch] = 0; m_tb[ch] = 0; m_en[ch] = 0;
            end else if (md == 2'd1 || md == 2'd2) begin
               v = int'(m_s[ch][2:0]);
               if (md == 2'd2) v = v ^ int'(tx_data[ch*3 +: 3]);
               i = (v < 4) ? v : v + 1;
               m_ta[ch] = tern(i / 3 - 1);
               m_tb[ch] = tern(i % 3 - 1);
               m_en[ch] = 1;
               m_s[ch]  = lfsr_adv(m_s[ch], master_slave[ch]);
            end else begin
               m_ta[ch] = 0; m_tb[ch] = 0; m_en[ch] = 0;
            end
            // Run length of the state-changing condition.
            if (m_lk[ch] == rcv_vld[ch]) m_run[ch] = 0;
            else m_run[ch] = m_run[ch] + 1;
            if (!m_lk[ch] && m_run[ch] == 16) begin
               m_lk[ch] = 1; m_run[ch] = 0;
            end else if (m_lk[ch] && m_run[ch] == 4) begin
               m_lk[ch] = 0; m_run[ch] = 0;
               if (m_llc[ch] < 255) m_llc[ch] = m_llc[ch] + 1;
            end
            if (seed_load[ch]) m_llc[ch] = 0;
         end
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk_33m);
      #1;
   endtask

   function automatic logic [NCH*6-1:0] exp_all();
      logic [NCH*2-1:0] ta, tb;
      logic [NCH-1:0]   en, lk;
      for (int ch = 0; ch < NCH; ch++) begin
         ta[ch*2 +: 2] = m_ta[ch];
         tb[ch*2 +: 2] = m_tb[ch];
         en[ch]        = m_en[ch];
         lk[ch]        = m_lk[ch];
      end
      return {ta, tb, en, lk};
   endfunction

   logic [NCH*6-1:0] dut_all;
   assign dut_all = {TAn, TBn, tx_enable, loc_rcvr_status};

   function automatic logic [SW-1:0] rnd_seed();
      logic [SW-1:0] r;
      r = {$urandom_range(1, 0) == 1, $urandom()};
      if ($urandom_range(7, 0) == 0) r = '0;
      return r;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 0; seed = '0; seed_load = '0; tx_mode = '0; master_slave = 4'b0101;
      tx_data = '0; rcv_vld = '0;
      tick(); tick();
      checks++;
      if (TAn !== '0 || TBn !== '0) begin
         errors++; $display("FAIL reset_sym: got TAn=%b TBn=%b want 0", TAn, TBn);
      end
      checks++;
      if (tx_enable !== '0) begin
         errors++; $display("FAIL reset_en: got %b want 0", tx_enable);
      end
      checks++;
      if (loc_rcvr_status !== '0) begin
         errors++; $display("FAIL reset_lock: got %b want 0", loc_rcvr_status);
      end
      rstn = 1;
   endtask

   task automatic run_seq_check(input string name);
      logic [3:0] want [4];
      want[0] = 4'b1100; want[1] = 4'b1101; want[2] = 4'b0001; want[3] = 4'b1111;
      tx_mode[1:0] = 2'd1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({TAn[1:0], TBn[1:0], tx_enable[0]} !== {want[k], 1'b1}) begin
            errors++;
            $display("FAIL %s step%0d: got TA=%b TB=%b en=%b want %b en=1",
                     name, k, TAn[1:0], TBn[1:0], tx_enable[0], want[k]);
         end
      end
   endtask

   task automatic test_seed_load();
      seed[SW-1:0] = 33'h1; seed_load[0] = 1; tx_mode = '0;
      tick();
      checks++;
      if (dut_all !== exp_all() || tx_enable[0] !== 1'b0) begin
         errors++; $display("FAIL seed_load_cycle: got %h want %h", dut_all, exp_all());
      end
      seed_load[0] = 0;
      run_seq_check("seed1");
   endtask

   task automatic test_zero_seed();
      tx_mode = '0; seed[SW-1:0] = '0; seed_load[0] = 1;
      tick();
      seed_load[0] = 0;
      run_seq_check("seed0");
      for (int k = 0; k < 40; k++) begin
         tick();
         checks++;
         if ({TAn[1:0], TBn[1:0]} === 4'b0000 || dut_all !== exp_all()) begin
            errors++; $display("FAIL zero_seed_run%0d: got %h want %h (never 0,0)", k, dut_all, exp_all());
         end
      end
   endtask

   task automatic test_payload();
      tx_mode = '0; seed[SW-1:0] = 33'h1; seed_load[0] = 1;
      tick();
      seed_load[0] = 0; tx_mode[1:0] = 2'd2; tx_data[2:0] = 3'b111;
      tick();
      checks++;
      if ({TAn[1:0], TBn[1:0]} !== 4'b0100) begin
         errors++; $display("FAIL payload_v6: got TA=%b TB=%b want 01 00", TAn[1:0], TBn[1:0]);
      end
      tx_mode[1:0] = 2'd0;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if ({TAn[1:0], TBn[1:0], tx_enable[0]} !== 5'b0) begin
            errors++; $display("FAIL send_z%0d: got TA=%b TB=%b en=%b want 0", k, TAn[1:0], TBn[1:0], tx_enable[0]);
         end
      end
      tx_mode[1:0] = 2'd1;
      tick();
      checks++;
      if ({TAn[1:0], TBn[1:0], tx_enable[0]} !== 5'b11011) begin
         errors++; $display("FAIL after_gap: got TA=%b TB=%b en=%b want 11 01 en=1", TAn[1:0], TBn[1:0], tx_enable[0]);
      end
      tx_mode = '0;
   endtask

   task automatic test_lock_hysteresis();
      int lvl [6];
      int len [6];
      lvl = '{1, 0, 1, 0, 1, 0};
      len = '{15, 1, 16, 3, 1, 4};
      rcv_vld = '0;
      for (int p = 0; p < 6; p++) begin
         for (int k = 0; k < len[p]; k++) begin
            logic want;
            rcv_vld[0] = lvl[p][0];
            tick();
            // Only the last edge of the 16-high run sets status; only the 4th low edge clears it.
            if (p < 2)       want = 0;
            else if (p == 2) want = (k == 15);
            else if (p < 5)  want = 1;
            else             want = (k != 3);
            checks++;
            if (loc_rcvr_status[0] !== want || dut_all !== exp_all()) begin
               errors++;
               $display("FAIL lock_p%0d_k%0d: got status=%b all=%h want status=%b all=%h",
                        p, k, loc_rcvr_status[0], dut_all, want, exp_all());
            end
         end
      end
      rcv_vld = '0;
   endtask

   task automatic random_cycles(input int n, input string name);
      for (int k = 0; k < n; k++) begin
         for (int ch = 0; ch < NCH; ch++) begin
            seed_load[ch] = ($urandom_range(15, 0) == 0);
            if (seed_load[ch]) seed[ch*SW +: SW] = rnd_seed();
            if ($urandom_range(9, 0) == 0) tx_mode[ch*2 +: 2] = 2'($urandom_range(3, 0));
            tx_data[ch*3 +: 3] = 3'($urandom_range(7, 0));
            if ($urandom_range(19, 0) == 0) rcv_vld[ch] = ~rcv_vld[ch];
         end
         tick();
         checks++;
         if (dut_all !== exp_all()) begin
            errors++; $display("FAIL %s cyc%0d: got %h want %h", name, k, dut_all, exp_all());
         end
      end
   endtask

   task automatic test_multi_channel();
      master_slave = 4'b0101;
      for (int ch = 0; ch < NCH; ch++) begin
         seed[ch*SW +: SW] = SW'(33'h1_2345_6789 * (ch + 1) + ch);
         tx_mode[ch*2 +: 2] = 2'(ch);
         rcv_vld[ch] = ch[0];
      end
      seed_load = '1;
      tick();
      seed_load = '0;
      tx_mode = {2'd1, 2'd2, 2'd1, 2'd2};
      rcv_vld = 4'b1111;
      for (int k = 0; k < 30; k++) begin
         tx_data = 12'($urandom());
         tick();
         checks++;
         if (dut_all !== exp_all()) begin
            errors++; $display("FAIL multi_fixed cyc%0d: got %h want %h", k, dut_all, exp_all());
         end
      end
      random_cycles(400, "multi_rand");
      rstn = 0;
      tick();
      checks++;
      if (dut_all !== '0) begin
         errors++; $display("FAIL mid_reset: got %h want 0", dut_all);
      end
      rstn = 1;
      random_cycles(100, "post_reset");
   endtask

`ifdef CON_LOCK_LOSS_CNT_EN
   task automatic test_lock_loss_cnt();
      seed_load = '0; rcv_vld = '0;
      for (int k = 0; k < 4; k++) tick();
      for (int r = 0; r < 300; r++) begin
         rcv_vld[1] = 1; for (int k = 0; k < 16; k++) tick();
         rcv_vld[1] = 0; for (int k = 0; k < 4; k++) tick();
      end
      checks++;
      if (lock_loss_cnt[15:8] !== 8'd255 || m_llc[1] != 255) begin
         errors++; $display("FAIL loss_sat: got %0d want 255", lock_loss_cnt[15:8]);
      end
      seed_load[1] = 1;
      tick();
      seed_load[1] = 0;
      checks++;
      if (lock_loss_cnt[15:8] !== 8'd0) begin
         errors++; $display("FAIL loss_clear: got %0d want 0", lock_loss_cnt[15:8]);
      end
   endtask
`endif

   initial begin
      for (int ch = 0; ch < NCH; ch++) begin
         m_s[ch] = 1; m_ta[ch] = 0; m_tb[ch] = 0; m_en[ch] = 0;
         m_lk[ch] = 0; m_run[ch] = 0; m_llc[ch] = 0;
      end
      test_reset();
      test_seed_load();
      test_zero_seed();
      test_payload();
      test_lock_hysteresis();
      test_multi_channel();
`ifdef CON_LOCK_LOSS_CNT_EN
      test_lock_loss_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
